vm_input_cond: RTL and testbench

- Input-conditioning stage directly upstream of the vending-machine FSM. Runs on the same divided 1 kHz clock as that FSM.
- Takes the raw slide-switch levels for coin, confirm, cancel and finish, and debounces them.
- Converts them into single-cycle event pulses. Validates the coin code and reports it as a 5-bit value.
- The downstream FSM then sees exactly one event per physical switch action.

---
 rtl/vm_pkg.sv | 25 ++
 rtl/sw_debounce.sv | 39 +++
 rtl/vm_input_cond.sv | 128 ++++++++++++
 tb/tb_vm_input_cond.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared coin constants, coin FSM state type and value decode
package vm_pkg;

  localparam int COIN_W = 3;

  localparam logic [4:0] COIN_V1  = 5'd1;
  localparam logic [4:0] COIN_V5  = 5'd5;
  localparam logic [4:0] COIN_V10 = 5'd10;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } coin_state_t;

  // Zero for any code that is not exactly one-hot.
  function automatic logic [4:0] coin_value(input logic [COIN_W-1:0] code);
    case (code)
      3'b001:  coin_value = COIN_V1;
      3'b010:  coin_value = COIN_V5;
      3'b100:  coin_value = COIN_V10;
      default: coin_value = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - vector debouncer, level accepted after a run of identical samples
module sw_debounce #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] cand_q;
  logic [CNT_W-1:0] cnt_q;

  // Any change restarts the run; a full run of a new value replaces the stable level.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= '0;
      cnt_q  <= '0;
      stable <= '0;
    end else if (raw != cand_q) begin
      cand_q <= raw;
      cnt_q  <= '0;
    end else if (cand_q != stable) begin
      if (cnt_q == CNT_LAST) begin
        stable <= cand_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/vm_input_cond.sv
// rtl/vm_input_cond.sv - switch debounce, edge events and coin validation (option: VM_INPUT_SYNC_EN)
module vm_input_cond
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COIN_W-1:0] i_coin,
  input  logic              i_confirm,
  input  logic              i_cancel,
  input  logic              i_finish,
  output logic              o_coin_valid,
  output logic [4:0]        o_coin_value,
  output logic              o_coin_err,
  output logic              o_confirm_p,
  output logic              o_cancel_p,
  output logic              o_finish_p
);

  logic [5:0] raw_all;

`ifdef VM_INPUT_SYNC_EN
  logic [5:0] sync1_q;
  logic [5:0] sync2_q;

  // Two-flop synchronizer in front of every debouncer for asynchronous switch levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {i_coin, i_confirm, i_cancel, i_finish};
      sync2_q <= sync1_q;
    end
  end

  assign raw_all = sync2_q;
`else
  assign raw_all = {i_coin, i_confirm, i_cancel, i_finish};
`endif

  logic [COIN_W-1:0] coin_stable;
  logic              conf_stable, canc_stable, fin_stable;
  logic              conf_prev_q, canc_prev_q, fin_prev_q;
  logic              conf_rise, canc_rise, fin_rise;

  sw_debounce #(.WIDTH(COIN_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_coin (
    .clk(clk), .reset(reset), .raw(raw_all[5:3]), .stable(coin_stable)
  );
  sw_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_confirm (
    .clk(clk), .reset(reset), .raw(raw_all[2]), .stable(conf_stable)
  );
  sw_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_cancel (
    .clk(clk), .reset(reset), .raw(raw_all[1]), .stable(canc_stable)
  );
  sw_debounce #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_finish (
    .clk(clk), .reset(reset), .raw(raw_all[0]), .stable(fin_stable)
  );

  assign conf_rise = conf_stable & ~conf_prev_q;
  assign canc_rise = canc_stable & ~canc_prev_q;
  assign fin_rise  = fin_stable  & ~fin_prev_q;

  // Rising-edge pulses; a simultaneous cancel masks confirm so the FSM never sees both.
  always_ff @(posedge clk) begin
    if (reset) begin
      conf_prev_q <= 1'b0;
      canc_prev_q <= 1'b0;
      fin_prev_q  <= 1'b0;
      o_confirm_p <= 1'b0;
      o_cancel_p  <= 1'b0;
      o_finish_p  <= 1'b0;
    end else begin
      conf_prev_q <= conf_stable;
      canc_prev_q <= canc_stable;
      fin_prev_q  <= fin_stable;
      o_confirm_p <= conf_rise & ~canc_rise;
      o_cancel_p  <= canc_rise;
      o_finish_p  <= fin_rise;
    end
  end

  coin_state_t state_q, state_d;
  logic        valid_d, err_d;
  logic [4:0]  value_d;

  // Coin state register with registered event outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      o_coin_valid <= 1'b0;
      o_coin_err   <= 1'b0;
      o_coin_value <= 5'd0;
    end else begin
      state_q      <= state_d;
      o_coin_valid <= valid_d;
      o_coin_err   <= err_d;
      o_coin_value <= value_d;
    end
  end

  // One event per insertion: report on leaving IDLE, then wait for the bus to clear.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    value_d = 5'd0;
    case (state_q)
      IDLE: begin
        if (coin_stable != '0) begin
          state_d = HOLD;
          if (coin_value(coin_stable) != 5'd0) begin
            valid_d = 1'b1;
            value_d = coin_value(coin_stable);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (coin_stable == '0) state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vm_input_cond.sv
// tb/tb_vm_input_cond.sv - scoreboard bench for vm_input_cond with a run-length reference model
module tb_vm_input_cond;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] i_coin = 3'b000;
  logic       i_confirm = 1'b0, i_cancel = 1'b0, i_finish = 1'b0;
  logic       o_coin_valid, o_coin_err, o_confirm_p, o_cancel_p, o_finish_p;
  logic [4:0] o_coin_value;

  vm_input_cond #(.DEBOUNCE_CYCLES(DC), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .i_coin(i_coin), .i_confirm(i_confirm),
    .i_cancel(i_cancel), .i_finish(i_finish), .o_coin_valid(o_coin_valid),
    .o_coin_value(o_coin_value), .o_coin_err(o_coin_err), .o_confirm_p(o_confirm_p),
    .o_cancel_p(o_cancel_p), .o_finish_p(o_finish_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
    logic [4:0] val;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0, n_fail = 0, cyc = 0;
  bit   rst_edge = 1'b0;

  logic [2:0] m_last [4];
  logic [2:0] m_stable [4];
  int         m_run [4];
  bit         m_armed;

  int n_valid = 0, n_err = 0, n_conf = 0, n_canc = 0, n_fin = 0;
  int last_valid_cyc = 0, last_err_cyc = 0, last_canc_cyc = 0, last_fin_cyc = 0;
  int last_val = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] dut_vec();
    return {o_coin_valid, o_coin_err, o_confirm_p, o_cancel_p, o_finish_p};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_last[c]   = 3'b000;
      m_stable[c] = 3'b000;
      m_run[c]    = 0;
    end
    m_armed = 1'b1;
  endtask

  // A channel adopts a new level once it has been sampled identically DC+1 edges in a row;
  // events appear on the edge after the level is adopted.
  task automatic model_step();
    logic [2:0] samp [4];
    logic [2:0] old [4];
    logic [4:0] vec, val;
    logic       conf, canc, fin;
    if (reset) begin
      rst_edge = 1'b1;
      model_reset();
      while (q.size() > 0 && q[q.size()-1].cyc >= cyc) void'(q.pop_back());
      return;
    end
    rst_edge = 1'b0;
    samp[0] = i_coin;
    samp[1] = {2'b00, i_confirm};
    samp[2] = {2'b00, i_cancel};
    samp[3] = {2'b00, i_finish};
    for (int c = 0; c < 4; c++) begin
      old[c] = m_stable[c];
      if (samp[c] == m_last[c]) m_run[c]++;
      else m_run[c] = 1;
      m_last[c] = samp[c];
      if (m_run[c] > DC && samp[c] != m_stable[c]) m_stable[c] = samp[c];
    end
    vec = 5'd0;
    val = 5'd0;
    if (m_stable[0] == 3'b000) begin
      m_armed = 1'b1;
    end else if (m_armed) begin
      m_armed = 1'b0;
      if ($countones(m_stable[0]) == 1) begin
        vec[4] = 1'b1;
        val = (m_stable[0] == 3'b001) ? 5'd1 : (m_stable[0] == 3'b010) ? 5'd5 : 5'd10;
      end else begin
        vec[3] = 1'b1;
      end
    end
    conf = m_stable[1][0] & ~old[1][0];
    canc = m_stable[2][0] & ~old[2][0];
    fin  = m_stable[3][0] & ~old[3][0];
    vec[2] = conf & ~canc;
    vec[1] = canc;
    vec[0] = fin;
    if (vec != 5'd0) q.push_back('{cyc + 1, vec, val});
  endtask

  task automatic drive(input logic [2:0] c, input logic cf, input logic cn,
                       input logic fn, input logic rs, input int n);
    repeat (n) begin
      @(negedge clk);
      i_coin = c; i_confirm = cf; i_cancel = cn; i_finish = fn; reset = rs;
      @(posedge clk);
      cyc++;
      model_step();
    end
  endtask

  // Monitor: compares every presented event with the scoreboard head.
  initial begin
    logic [4:0] v;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        v = dut_vec();
        if (rst_edge) begin
          chk("reset_outputs_zero", int'({v, o_coin_value}), 0);
        end else begin
          while (q.size() > 0 && q[0].cyc < cyc) begin
            chk("missed_event", 0, int'(q[0].vec));
            void'(q.pop_front());
          end
          if (v != 5'd0) begin
            if (q.size() == 0 || q[0].cyc != cyc) begin
              chk("unexpected_event", int'(v), 0);
            end else begin
              chk("event_kind", int'(v), int'(q[0].vec));
              chk("event_value", int'(o_coin_value), int'(q[0].val));
              void'(q.pop_front());
            end
          end else if (q.size() > 0 && q[0].cyc == cyc) begin
            chk("missed_event", 0, int'(q[0].vec));
            void'(q.pop_front());
          end
          if (!o_coin_valid) chk("value_idle_zero", int'(o_coin_value), 0);
        end
        if (o_coin_valid) begin n_valid++; last_valid_cyc = cyc; last_val = int'(o_coin_value); end
        if (o_coin_err)   begin n_err++;   last_err_cyc = cyc; end
        if (o_confirm_p)  n_conf++;
        if (o_cancel_p)   begin n_canc++;  last_canc_cyc = cyc; end
        if (o_finish_p)   begin n_fin++;   last_fin_cyc = cyc; end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, b_valid, b_err, b_conf, b_canc, b_fin;
    model_reset();

    drive(3'b000, 0, 0, 0, 1, 3);
    #1 chk("reset_state", int'({dut_vec(), o_coin_value}), 0);
    drive(3'b000, 0, 0, 0, 0, 5);

    // Held 5-unit coin: exactly one event.
    b_valid = n_valid; b_err = n_err;
    drive(3'b010, 0, 0, 0, 0, 1); k = cyc;
    drive(3'b010, 0, 0, 0, 0, 49);
    drive(3'b000, 0, 0, 0, 0, 10);
    chk("s1_valid_count", n_valid - b_valid, 1);
    chk("s1_latency", last_valid_cyc - k, DC + 1);
    chk("s1_value", last_val, 5);
    chk("s1_err_count", n_err - b_err, 0);

    // Bouncing coin never settles.
    b_valid = n_valid; b_err = n_err;
    for (int i = 0; i < 5; i++) begin
      drive(3'b100, 0, 0, 0, 0, 2);
      drive(3'b000, 0, 0, 0, 0, 2);
    end
    drive(3'b000, 0, 0, 0, 0, 10);
    chk("s2_valid_count", n_valid - b_valid, 0);
    chk("s2_err_count", n_err - b_err, 0);

    // Multi-bit code rejected, then a clean 1-unit coin.
    b_valid = n_valid; b_err = n_err;
    drive(3'b011, 0, 0, 0, 0, 1); k = cyc;
    drive(3'b011, 0, 0, 0, 0, 11);
    chk("s3_err_count", n_err - b_err, 1);
    chk("s3_err_latency", last_err_cyc - k, DC + 1);
    chk("s3_valid_none", n_valid - b_valid, 0);
    drive(3'b000, 0, 0, 0, 0, 8);
    drive(3'b001, 0, 0, 0, 0, 1); k = cyc;
    drive(3'b001, 0, 0, 0, 0, 10);
    drive(3'b000, 0, 0, 0, 0, 8);
    chk("s3_valid_count", n_valid - b_valid, 1);
    chk("s3_valid_latency", last_valid_cyc - k, DC + 1);
    chk("s3_value", last_val, 1);

    // Confirm and cancel together: cancel wins.
    b_conf = n_conf; b_canc = n_canc; b_fin = n_fin;
    drive(3'b000, 1, 1, 0, 0, 1); k = cyc;
    drive(3'b000, 1, 1, 0, 0, 10);
    chk("s4_cancel_count", n_canc - b_canc, 1);
    chk("s4_cancel_latency", last_canc_cyc - k, DC + 1);
    chk("s4_confirm_none", n_conf - b_conf, 0);
    drive(3'b000, 0, 0, 0, 0, 10);
    chk("s4_release_cancel", n_canc - b_canc, 1);
    chk("s4_release_confirm", n_conf - b_conf, 0);
    chk("s4_finish_none", n_fin - b_fin, 0);

    // Reset while holding a 10-unit coin gives a fresh event afterwards.
    b_valid = n_valid;
    drive(3'b100, 0, 0, 0, 0, 1); k = cyc;
    drive(3'b100, 0, 0, 0, 0, 7);
    chk("s5_first_latency", last_valid_cyc - k, DC + 1);
    chk("s5_first_value", last_val, 10);
    drive(3'b100, 0, 0, 0, 1, 2);
    #1 chk("s5_reset_outputs", int'({dut_vec(), o_coin_value}), 0);
    drive(3'b100, 0, 0, 0, 0, 1); k = cyc;
    drive(3'b100, 0, 0, 0, 0, 10);
    drive(3'b000, 0, 0, 0, 0, 8);
    chk("s5_valid_count", n_valid - b_valid, 2);
    chk("s5_second_latency", last_valid_cyc - k, DC + 1);
    chk("s5_second_value", last_val, 10);

    // Finish: short pulse rejected, longer hold accepted.
    b_fin = n_fin;
    drive(3'b000, 0, 0, 1, 0, 3);
    drive(3'b000, 0, 0, 0, 0, 10);
    chk("s6_short_finish", n_fin - b_fin, 0);
    drive(3'b000, 0, 0, 1, 0, 1); k = cyc;
    drive(3'b000, 0, 0, 1, 0, 5);
    drive(3'b000, 0, 0, 0, 0, 10);
    chk("s6_finish_count", n_fin - b_fin, 1);
    chk("s6_finish_latency", last_fin_cyc - k, DC + 1);

    // Randomized levels and hold times, with occasional resets.
    for (int i = 0; i < 150; i++) begin
      logic [2:0] c;
      logic cf, cn, fn;
      int d;
      c  = 3'($urandom_range(0, 7));
      cf = 1'($urandom_range(0, 1));
      cn = 1'($urandom_range(0, 1));
      fn = 1'($urandom_range(0, 1));
      d  = $urandom_range(1, 9);
      if ($urandom_range(0, 39) == 0) drive(c, cf, cn, fn, 1, $urandom_range(1, 2));
      drive(c, cf, cn, fn, 0, d);
    end
    drive(3'b000, 0, 0, 0, 0, 20);
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
